// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main controller for a multi-cycle RISC-V style datapath. It steps each
// instruction through fetch / decode / execute / memory / writeback. It drives
// the datapath mux selects and enables, and the ALUOp field that feeds the
// downstream ALU_decoder.
//
// Supported instructions: lw, sw, R-type, I-type ALU, jal, beq.
//
// Almost every output is a Moore decode of the current state. There are two
// exceptions:
//   - PCWrite also uses the ALU zero flag, so that beq can branch.
//   - ImmSrc is decoded from op_code alone and does not depend on the state.
//
// Parameters
//   MEM_LAT   cycles that each memory access state occupies
//             (FETCH, MEMREAD, MEMWRITE). Legal range is 1..15.
//
// Optional build macro
//   ILLEGAL_TRAP_EN   When defined, an unknown opcode in DECODE moves the FSM
//                     into an absorbing ILLEGAL state and sets the sticky
//                     'illegal' flag. When undefined, an unknown opcode is
//                     treated as a NOP: the FSM returns to FETCH and the PC
//                     has already advanced. 'illegal' is then tied to 0.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   op_code    in   7  opcode from the instruction register (valid from DECODE)
//   zero       in   1  ALU zero flag
//   PCWrite    out  1  PC register enable
//   AdrSrc     out  1  memory address mux: 0=PC, 1=ALUOut
//   MemWrite   out  1  data memory write enable
//   IRWrite    out  1  instruction/OldPC register enable
//   ResultSrc  out  2  result mux: 00=ALUOut, 01=ReadData, 10=ALUResult
//   ALUSrcA    out  2  A mux: 00=PC, 01=OldPC, 10=rs1
//   ALUSrcB    out  2  B mux: 00=rs2, 01=imm, 10=const 4
//   ALUOp      out  2  to ALU_decoder: 00=add, 01=sub, 10=funct-decoded
//   ImmSrc     out  2  immediate format: 00=I, 01=S, 10=B, 11=J
//   RegWrite   out  1  register file write enable
//   state_o    out  4  current state encoding (debug)
//   illegal    out  1  sticky illegal-opcode flag
// ----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_code,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] state_o,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Terminal count of the wait counter. A memory access state advances on
    // the cycle in which the counter equals this value.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wait_done;
    logic       mem_state;
    logic       pc_update;
    logic       branch;

    // ------------------------------------------------------------------
    // State and wait-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wait_done = (cnt_q == LAST_CNT);
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;

        // The counter only runs while a memory state is held. It drops back
        // to 0 on the cycle that a memory state completes. Non-memory states
        // keep it at 0. As a result, every entry into FETCH, MEMREAD or
        // MEMWRITE starts with a cleared count.
        if (mem_state && !wait_done) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd0;
        end

        case (state_q)
            S_FETCH: begin
                if (wait_done) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_code)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_ILLEGAL;
`else
                    // Unknown opcode behaves as a NOP. The PC was already
                    // advanced in FETCH.
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            // Bit 5 of the opcode separates store (0100011) from load (0000011).
            S_MEMADR:   state_d = op_code[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (wait_done) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (wait_done) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed on every fetch cycle. The IR and the
                // PC only capture it once the memory read has settled.
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = wait_done;
                pc_update = wait_done;
            end
            S_DECODE: begin
                // Precompute OldPC + imm as the branch/jump target.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                // A single write strobe, aligned to the end of the access.
                AdrSrc   = 1'b1;
                MemWrite = wait_done;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                // The PC takes the target from ALUOut. OldPC + 4 becomes the
                // link value, which is written back in ALUWB.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            default: begin
                // ILLEGAL and unused encodings: every enable stays low.
            end
        endcase
    end

    // zero only matters in BEQ, because branch is low everywhere else.
    assign PCWrite = pc_update | (branch & zero);

    // ------------------------------------------------------------------
    // Immediate format. This is decoded from op_code alone, with no
    // dependence on the state.
    // ------------------------------------------------------------------
    always_comb begin
        case (op_code)
            OP_LW, OP_ITYPE: ImmSrc = 2'b00;
            OP_SW:           ImmSrc = 2'b01;
            OP_BEQ:          ImmSrc = 2'b10;
            OP_JAL:          ImmSrc = 2'b11;
            default:         ImmSrc = 2'b00;
        endcase
    end

    assign state_o = state_q;

    // ------------------------------------------------------------------
    // Sticky illegal flag
    // ------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // ILLEGAL is absorbing, so the flag sets on entry and holds until rst.
    always_comb begin
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // State numbers as documented for state_o.
    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                   MEMWRITE = 5, EXECUTER = 6, ALUWB = 7, EXECUTEI = 8,
                   JALS = 9, BEQS = 10, ILLEGALS = 11;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic [1:0] imm;
        logic       rw;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op_code;
    logic       zero;

    logic       pcw [2];
    logic       adr [2];
    logic       mw  [2];
    logic       irw [2];
    logic       rw  [2];
    logic       ill [2];
    logic [1:0] rs  [2];
    logic [1:0] sa  [2];
    logic [1:0] sb  [2];
    logic [1:0] aop [2];
    logic [1:0] imm [2];
    logic [3:0] st  [2];

    // Lane 0 uses MEM_LAT=1 and lane 1 uses MEM_LAT=3. Both share the inputs;
    // only the lane selected by 'cur' is checked at any time.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            multicycle_control_fsm #(.MEM_LAT(gi == 0 ? 1 : 3)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .op_code  (op_code),
                .zero     (zero),
                .PCWrite  (pcw[gi]),
                .AdrSrc   (adr[gi]),
                .MemWrite (mw[gi]),
                .IRWrite  (irw[gi]),
                .ResultSrc(rs[gi]),
                .ALUSrcA  (sa[gi]),
                .ALUSrcB  (sb[gi]),
                .ALUOp    (aop[gi]),
                .ImmSrc   (imm[gi]),
                .RegWrite (rw[gi]),
                .state_o  (st[gi]),
                .illegal  (ill[gi])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cur = 0;
    bit   active = 1'b0;

    logic [6:0] op_tab [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

    function automatic int lat();
        return (cur == 0) ? 1 : 3;
    endfunction

    // Expected outputs for one cycle. 'last' marks the final cycle of a
    // memory access.
    function automatic vec_t model(int s, bit last, logic [6:0] op, logic z);
        vec_t v;
        v = '0;
        v.st = 4'(s);
        if (op == OP_SW)       v.imm = 2'b01;
        else if (op == OP_BEQ) v.imm = 2'b10;
        else if (op == OP_JAL) v.imm = 2'b11;
        else                   v.imm = 2'b00;
        case (s)
            FETCH:    begin v.sb = 2'b10; v.rs = 2'b10; v.irw = last; v.pcw = last; end
            DECODE:   begin v.sa = 2'b01; v.sb = 2'b01; end
            MEMADR:   begin v.sa = 2'b10; v.sb = 2'b01; end
            MEMREAD:  begin v.adr = 1'b1; end
            MEMWB:    begin v.rs = 2'b01; v.rw = 1'b1; end
            MEMWRITE: begin v.adr = 1'b1; v.mw = last; end
            EXECUTER: begin v.sa = 2'b10; v.aop = 2'b10; end
            EXECUTEI: begin v.sa = 2'b10; v.sb = 2'b01; v.aop = 2'b10; end
            ALUWB:    begin v.rw = 1'b1; end
            JALS:     begin v.sa = 2'b01; v.sb = 2'b10; v.pcw = 1'b1; end
            BEQS:     begin v.sa = 2'b10; v.aop = 2'b01; v.pcw = z; end
            ILLEGALS: begin v.ill = 1'b1; end
            default:  begin end
        endcase
        return v;
    endfunction

    function automatic vec_t actual(int l);
        return {st[l], pcw[l], adr[l], mw[l], irw[l], rs[l], sa[l], sb[l],
                aop[l], imm[l], rw[l], ill[l]};
    endfunction

    task automatic check(string name, vec_t got, vec_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s lane%0d: got=%h (state %0d) required=%h (state %0d)",
                     name, cur, got, got.st, want, want.st);
        end
    endtask

    task automatic push_state(int s, int n, logic [6:0] op, logic z);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(s, i == n - 1, op, z));
        end
    endtask

    // Apply one instruction just after a rising edge. Queue its
    // cycle-by-cycle expectation, then let it run to completion.
    task automatic issue(logic [6:0] op, logic z);
        int n0;
        int n;
        op_code = op;
        zero    = z;
        n0 = exp_q.size();
        push_state(FETCH, lat(), op, z);
        push_state(DECODE, 1, op, z);
        case (op)
            OP_LW:  begin push_state(MEMADR, 1, op, z); push_state(MEMREAD, lat(), op, z);
                          push_state(MEMWB, 1, op, z); end
            OP_SW:  begin push_state(MEMADR, 1, op, z); push_state(MEMWRITE, lat(), op, z); end
            OP_R:   begin push_state(EXECUTER, 1, op, z); push_state(ALUWB, 1, op, z); end
            OP_I:   begin push_state(EXECUTEI, 1, op, z); push_state(ALUWB, 1, op, z); end
            OP_JAL: begin push_state(JALS, 1, op, z); push_state(ALUWB, 1, op, z); end
            OP_BEQ: begin push_state(BEQS, 1, op, z); end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                push_state(ILLEGALS, 6, op, z);
`endif
            end
        endcase
        n = exp_q.size() - n0;
        $display("txn lane=%0d op=%b zero=%b cycles=%0d", cur, op, z, n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares one queued expectation per cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (active) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL underflow lane%0d: got state %0d, required a queued expectation",
                             cur, st[cur]);
                end else begin
                    check("cycle", actual(cur), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        op_code = OP_R;
        zero    = 1'b0;
        for (int lane = 0; lane < 2; lane++) begin
            cur = lane;
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("reset", actual(cur), model(FETCH, lat() == 1, op_code, zero));
            rst    = 1'b0;
            active = 1'b1;

            issue(OP_LW, 1'b0);
            issue(OP_SW, 1'b1);
            issue(OP_BEQ, 1'b1);
            issue(OP_BEQ, 1'b0);
            issue(OP_R, 1'b1);
            issue(OP_I, 1'b0);
            issue(OP_JAL, 1'b1);
            for (int k = 0; k < 30; k++) begin
                issue(op_tab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
            end
            issue(OP_BAD, 1'b0);
`ifndef ILLEGAL_TRAP_EN
            issue(OP_LW, 1'b1);
`endif
            active = 1'b0;
            if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL drain lane%0d: got %0d leftover, required 0", cur, exp_q.size());
                exp_q.delete();
            end

            // Asynchronous reset in the middle of MEMREAD.
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst     = 1'b0;
            op_code = OP_LW;
            zero    = 1'b0;
            repeat (lat() + 2) begin
                @(posedge clk);
                #1;
            end
            if (lat() > 1) begin
                @(posedge clk);
                #1;
            end
            #2;
            check("pre_reset_memread", actual(cur), model(MEMREAD, lat() == 1, op_code, zero));
            rst = 1'b1;
            #1;
            check("async_reset", actual(cur), model(FETCH, lat() == 1, op_code, zero));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
